// File: rtl/oled_byte_arbiter.sv
// Round-robin arbiter that shares the oled_cntrl byte port between NUM_REQ packet sources.
// A grant is held for a whole packet, and every byte goes through a 4-phase valid/done handshake.
module oled_byte_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int PKT_TIMEOUT = 0,
  parameter int CELLS       = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 oled_data,
  output logic                       oled_data_valid,
  input  logic                       oled_done,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic [$clog2(CELLS)-1:0]   cursor,
  output logic                       timeout_pulse,
  output logic [1:0]                 fsm_state
);

  localparam int CW = $clog2(CELLS);
  localparam int GW = (PKT_TIMEOUT > 1) ? $clog2(PKT_TIMEOUT) : 1;

  typedef enum logic [1:0] {ARB = 2'd0, LOAD = 2'd1, SEND = 2'd2, RELEASE = 2'd3} state_t;

  state_t          state, state_next;
  logic [2:0]      last_grant, pick;
  logic            any_valid, sel_valid, sel_last, last_q;
  logic [7:0]      sel_data;
  logic [GW-1:0]   gap;
  logic            load_ok, timed_out;
  logic            do_grant, do_load, do_wait, do_sent, do_close;

  // First requester with valid set, searching upward from the one after last_grant.
  always_comb begin
    pick = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (i == (int'(last_grant) + k) % NUM_REQ)) pick = 3'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign any_valid = |req_valid;
  assign load_ok   = sel_valid && !oled_done;
  assign timed_out = (PKT_TIMEOUT != 0) && (32'(gap) == 32'(PKT_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (any_valid) state_next = LOAD;
      LOAD:    if (load_ok) state_next = SEND;
               else if (timed_out) state_next = ARB;
      SEND:    if (oled_done) state_next = RELEASE;
      RELEASE: if (!oled_done) state_next = last_q ? ARB : LOAD;
      default: state_next = ARB;
    endcase
  end

  // Byte handshake: req_ready[i] pulses on the cycle the granted byte is taken; toward
  // oled_cntrl, data_valid rises with data stable, falls on done=1, next byte only after done=0.
  always_comb begin
    do_grant  = (state == ARB) && any_valid;
    do_load   = (state == LOAD) && load_ok;
    do_wait   = (state == LOAD) && !load_ok;
    do_sent   = (state == SEND) && oled_done;
    do_close  = (state == RELEASE) && !oled_done && last_q;
    fsm_state = state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready       <= '0;
      oled_data       <= 8'h00;
      oled_data_valid <= 1'b0;
      grant_id        <= 3'd0;
      busy            <= 1'b0;
      cursor          <= '0;
      timeout_pulse   <= 1'b0;
      last_grant      <= 3'(NUM_REQ - 1);
      last_q          <= 1'b0;
      gap             <= '0;
    end else begin
      req_ready     <= '0;
      timeout_pulse <= 1'b0;
      if (do_grant) begin
        grant_id <= pick;
        busy     <= 1'b1;
        gap      <= '0;
      end
      if (do_load) begin
        oled_data       <= sel_data;
        last_q          <= sel_last;
        oled_data_valid <= 1'b1;
        gap             <= '0;
        for (int i = 0; i < NUM_REQ; i++) req_ready[i] <= (grant_id == 3'(i));
      end
      if (do_wait) begin
        if (timed_out) begin
          timeout_pulse <= 1'b1;
          last_grant    <= grant_id;
          busy          <= 1'b0;
          gap           <= '0;
        end else if (PKT_TIMEOUT != 0) begin
          gap <= gap + 1'b1;
        end
      end
      if (do_sent) begin
        oled_data_valid <= 1'b0;
        cursor          <= (cursor == CW'(CELLS - 1)) ? '0 : cursor + 1'b1;
      end
      if (do_close) begin
        last_grant <= grant_id;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oled_byte_arbiter.sv
// Directed bench for oled_byte_arbiter: packet tables run through a requester/done model,
// plus hand-timed sequences for latency, timeout and reset-during-send.
module tb_oled_byte_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic        oled_done, oled_data_valid, busy, timeout_pulse;
  logic [7:0]  oled_data;
  logic [2:0]  grant_id;
  logic [5:0]  cursor;
  logic [1:0]  fsm_state;

  logic [1:0]  t_valid, t_last, t_ready;
  logic [15:0] t_data;
  logic        t_done, t_ovalid, t_busy, t_tpulse;
  logic [7:0]  t_odata;
  logic [2:0]  t_grant;
  logic [5:0]  t_cursor;
  logic [1:0]  t_state;

  oled_byte_arbiter #(.NUM_REQ(2), .PKT_TIMEOUT(0), .CELLS(64)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .oled_data(oled_data),
    .oled_data_valid(oled_data_valid), .oled_done(oled_done), .grant_id(grant_id),
    .busy(busy), .cursor(cursor), .timeout_pulse(timeout_pulse), .fsm_state(fsm_state));

  oled_byte_arbiter #(.NUM_REQ(2), .PKT_TIMEOUT(20), .CELLS(64)) dut_to (
    .clock(clock), .reset(reset), .req_valid(t_valid), .req_data(t_data),
    .req_last(t_last), .req_ready(t_ready), .oled_data(t_odata),
    .oled_data_valid(t_ovalid), .oled_done(t_done), .grant_id(t_grant),
    .busy(t_busy), .cursor(t_cursor), .timeout_pulse(t_tpulse), .fsm_state(t_state));

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
    bit         late;
    logic [10:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [10:0] exp_q[$];
  logic [8:0]  src0_q[$];
  logic [8:0]  src1_q[$];
  int          checks = 0;
  int          fails = 0;
  int          busy_cnt = 0;
  int          ready_viol = 0;
  int          valid_seen = 0;
  bit          done_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic enqueue(input int src, input logic [7:0] data, input logic last);
    if (src == 0) src0_q.push_back({last, data});
    else          src1_q.push_back({last, data});
  endtask

  task automatic capture();
    logic [10:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL byte: got grant %0d data 0x%0h, expected no byte", grant_id, oled_data);
    end else begin
      e = exp_q.pop_front();
      if ({grant_id, oled_data} !== e) begin
        fails++;
        $display("FAIL byte: got grant %0d data 0x%0h, expected grant %0d data 0x%0h",
                 grant_id, oled_data, e[10:8], e[7:0]);
      end
    end
  endtask

  // One cycle: sample at the falling edge, run the requester and done models, drive inputs.
  task automatic step();
    @(negedge clock);
    if ($countones(req_ready) > 1) ready_viol++;
    if (req_ready != 2'b00 && (req_ready != (2'b01 << grant_id) || !oled_data_valid)) ready_viol++;
    if (oled_data_valid) valid_seen++;
    if (req_ready[0]) begin
      if (src0_q.size() > 0) void'(src0_q.pop_front());
      else ready_viol++;
    end
    if (req_ready[1]) begin
      if (src1_q.size() > 0) void'(src1_q.pop_front());
      else ready_viol++;
    end
    if (done_force) oled_done = 1'b1;
    else if (oled_done) begin
      if (!oled_data_valid) oled_done = 1'b0;
    end else if (oled_data_valid) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        busy_cnt  = 0;
        oled_done = 1'b1;
        capture();
      end
    end
    req_valid[0] = (src0_q.size() != 0);
    req_valid[1] = (src1_q.size() != 0);
    req_data     = 16'h0000;
    req_last     = 2'b00;
    if (src0_q.size() != 0) begin
      req_data[7:0] = src0_q[0][7:0];
      req_last[0]   = src0_q[0][8];
    end
    if (src1_q.size() != 0) begin
      req_data[15:8] = src1_q[0][7:0];
      req_last[1]    = src1_q[0][8];
    end
  endtask

  function automatic bit idle();
    return src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 && !busy && !oled_done;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    done_force = 1'b0;
    oled_done = 1'b0;
    req_valid = 2'b00;
    req_data = 16'h0000;
    req_last = 2'b00;
    t_valid = 2'b00;
    t_data = 16'h0000;
    t_last = 2'b00;
    t_done = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!idle() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_drain: still busy after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
    end
  endtask

  task automatic run_table(input string name, input int first, input int n);
    bit late_pending = 1'b0;
    int cyc = 0;
    for (int i = first; i < first + n; i++) begin
      exp_q.push_back(vecs[i].exp);
      if (vecs[i].late) late_pending = 1'b1;
      else enqueue(vecs[i].src, vecs[i].data, vecs[i].last);
    end
    while (cyc < 3000 && (late_pending || !idle())) begin
      step();
      cyc++;
      if (late_pending && exp_q.size() < n) begin
        for (int i = first; i < first + n; i++)
          if (vecs[i].late) enqueue(vecs[i].src, vecs[i].data, vecs[i].last);
        late_pending = 1'b0;
      end
    end
    checks++;
    if (cyc >= 3000) begin
      fails++;
      $display("FAIL %s_drain: still busy after %0d cycles, %0d bytes outstanding", name, cyc, exp_q.size());
    end
  endtask

  initial begin
    int k;
    int wrap_at;
    bit saw63;
    vecs[0] = '{0, 8'h48, 1'b0, 1'b0, {3'd0, 8'h48}};
    vecs[1] = '{0, 8'h49, 1'b1, 1'b0, {3'd0, 8'h49}};
    vecs[2] = '{0, 8'h41, 1'b1, 1'b0, {3'd0, 8'h41}};
    vecs[3] = '{1, 8'h42, 1'b1, 1'b0, {3'd1, 8'h42}};
    vecs[4] = '{0, 8'h44, 1'b1, 1'b0, {3'd0, 8'h44}};
    vecs[5] = '{1, 8'h43, 1'b1, 1'b0, {3'd1, 8'h43}};
    vecs[6] = '{0, 8'h31, 1'b0, 1'b0, {3'd0, 8'h31}};
    vecs[7] = '{0, 8'h32, 1'b0, 1'b0, {3'd0, 8'h32}};
    vecs[8] = '{0, 8'h33, 1'b1, 1'b0, {3'd0, 8'h33}};
    vecs[9] = '{1, 8'h7A, 1'b1, 1'b1, {3'd1, 8'h7A}};

    do_reset();
    check("rst_ready", req_ready, 0);
    check("rst_valid", oled_data_valid, 0);
    check("rst_data", oled_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor", cursor, 0);
    check("rst_state", fsm_state, 0);

    // ARB -> LOAD -> SEND latency with a single-byte packet
    enqueue(0, 8'h5A, 1'b1);
    exp_q.push_back({3'd0, 8'h5A});
    step();
    step();
    check("lat_busy", busy, 1);
    check("lat_state_load", fsm_state, 1);
    check("lat_valid_early", oled_data_valid, 0);
    step();
    check("lat_valid", oled_data_valid, 1);
    check("lat_ready", req_ready, 2'b01);
    check("lat_data", oled_data, 8'h5A);
    step();
    check("lat_ready_pulse", req_ready, 2'b00);
    wait_idle("lat", 100);
    check("lat_cursor", cursor, 1);
    check("lat_data_hold", oled_data, 8'h5A);

    do_reset();
    run_table("hi", 0, 2);
    check("hi_cursor", cursor, 2);
    check("hi_busy", busy, 0);
    check("hi_state", fsm_state, 0);

    do_reset();
    run_table("rr", 2, 4);
    check("rr_cursor", cursor, 4);
    check("rr_grant", grant_id, 1);

    do_reset();
    run_table("hold", 6, 4);
    check("hold_cursor", cursor, 4);

    // 70 single-byte packets alternating between requesters
    do_reset();
    for (int i = 0; i < 70; i++) begin
      enqueue(i % 2, 8'(8'h20 + i), 1'b1);
      exp_q.push_back({3'(i % 2), 8'(8'h20 + i)});
    end
    k = 0;
    wrap_at = -1;
    saw63 = 1'b0;
    while (!idle() && k < 3000) begin
      step();
      k++;
      if (cursor == 6'd63) saw63 = 1'b1;
      if (saw63 && cursor == 6'd0 && wrap_at < 0) wrap_at = 70 - exp_q.size();
    end
    check("wrap_drain", k < 3000, 1);
    check("wrap_seen63", saw63, 1);
    check("wrap_at_byte", wrap_at, 64);
    check("wrap_cursor", cursor, 6);

    // done held high: no byte may go out; then reset in the middle of SEND
    done_force = 1'b1;
    step();
    enqueue(1, 8'h55, 1'b1);
    valid_seen = 0;
    repeat (100) step();
    check("stall_no_valid", valid_seen, 0);
    check("stall_state", fsm_state, 1);
    check("stall_busy", busy, 1);
    done_force = 1'b0;
    k = 0;
    while (!oled_data_valid && k < 10) begin
      step();
      k++;
    end
    check("stall_release_valid", oled_data_valid, 1);
    check("stall_send_state", fsm_state, 2);
    reset = 1'b1;
    src1_q.delete();
    step();
    check("midrst_valid", oled_data_valid, 0);
    check("midrst_data", oled_data, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cursor", cursor, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_tpulse", timeout_pulse, 0);
    check("midrst_state", fsm_state, 0);
    reset = 1'b0;

    // open packet abandoned by req0 on the timeout instance
    do_reset();
    @(negedge clock);
    t_valid = 2'b11;
    t_data  = {8'h5A, 8'h41};
    t_last  = 2'b10;
    @(negedge clock);
    check("to_busy", t_busy, 1);
    @(negedge clock);
    check("to_ready", t_ready, 2'b01);
    check("to_data", t_odata, 8'h41);
    t_valid[0] = 1'b0;
    t_done = 1'b1;
    @(negedge clock);
    check("to_valid_drop", t_ovalid, 0);
    t_done = 1'b0;
    k = 0;
    while (!t_tpulse && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("to_pulse_cycle", k, 21);
    check("to_busy_low", t_busy, 0);
    check("to_state_arb", t_state, 0);
    @(negedge clock);
    check("to_pulse_once", t_tpulse, 0);
    check("to_regrant", t_grant, 1);
    @(negedge clock);
    check("to_req1_ready", t_ready, 2'b10);
    check("to_req1_data", t_odata, 8'h5A);
    t_valid = 2'b00;
    t_done = 1'b1;
    @(negedge clock);
    t_done = 1'b0;
    repeat (2) @(negedge clock);
    check("to_end_busy", t_busy, 0);
    check("to_end_cursor", t_cursor, 2);

    check("ready_rules", ready_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
